// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA initiator for the PPU VRAM configuration port.
// Define PPU_PLT_DIRECT_RD_EN to return palette-space reads directly instead of via the read buffer.
module ppu_vram_port #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       i_cpu_clk,
  input  logic       i_cpu_rst,
  input  logic       i_reg_cs,
  input  logic       i_reg_sel,
  input  logic       i_reg_we,
  input  logic [7:0] i_reg_wdata,
  input  logic       i_inc32,
  input  logic       i_latch_clr,
  output logic [7:0] o_reg_rdata,
  output logic       o_reg_rvalid,
  output logic       o_busy,
  output logic [15:0] o_vram_addr,
  output logic       o_vram_we,
  output logic [7:0] o_vram_wdata,
  input  logic [7:0] i_vram_rdata
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdCap} state_e;

  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  state_e      r_state;
  logic [1:0]  r_cnt;
  logic [13:0] r_v;
  logic        r_w;
  logic [7:0]  r_rbuf;
  logic        r_plt;
  logic        r_busy;
  logic [7:0]  r_rdata;
  logic        r_rvalid;
  logic [15:0] r_vram_addr;
  logic        r_vram_we;
  logic [7:0]  r_vram_wdata;

  logic        w_addr_wr;
  logic        w_addr_rd;
  logic        w_data_wr;
  logic        w_data_rd;
  logic        w_plt;
  logic [13:0] w_v_inc;

  // Every CPU access except the w clear is dropped while a read is in flight.
  assign w_addr_wr = i_reg_cs & ~i_reg_sel & i_reg_we & ~r_busy;
  assign w_addr_rd = i_reg_cs & ~i_reg_sel & ~i_reg_we & ~r_busy;
  assign w_data_wr = i_reg_cs & i_reg_sel & i_reg_we & ~r_busy;
  assign w_data_rd = i_reg_cs & i_reg_sel & ~i_reg_we & ~r_busy;
  assign w_v_inc   = r_v + (i_inc32 ? 14'd32 : 14'd1);

`ifdef PPU_PLT_DIRECT_RD_EN
  assign w_plt = (r_v[13:8] == 6'h3F);
`else
  assign w_plt = 1'b0;
`endif

  always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      r_state      <= StIdle;
      r_cnt        <= 2'd0;
      r_v          <= 14'd0;
      r_w          <= 1'b0;
      r_rbuf       <= 8'd0;
      r_plt        <= 1'b0;
      r_busy       <= 1'b0;
      r_rdata      <= 8'd0;
      r_rvalid     <= 1'b0;
      r_vram_addr  <= 16'd0;
      r_vram_we    <= 1'b0;
      r_vram_wdata <= 8'd0;
    end else begin
      r_vram_we <= 1'b0;
      r_rvalid  <= 1'b0;

      // A coincident PPUSTATUS read wins over the PPUADDR write.
      if (i_latch_clr) begin
        r_w <= 1'b0;
      end else if (w_addr_wr) begin
        if (!r_w) r_v[13:8] <= i_reg_wdata[5:0];
        else      r_v[7:0]  <= i_reg_wdata;
        r_w <= ~r_w;
      end

      if (w_addr_rd) begin
        r_rdata  <= 8'd0;
        r_rvalid <= 1'b1;
      end

      if (w_data_wr) begin
        r_vram_addr  <= {2'b00, r_v};
        r_vram_wdata <= i_reg_wdata;
        r_vram_we    <= 1'b1;
        r_v          <= w_v_inc;
      end

      unique case (r_state)
        StIdle: begin
          if (w_data_rd) begin
            r_vram_addr <= {2'b00, r_v};
            r_v         <= w_v_inc;
            r_plt       <= w_plt;
            r_cnt       <= CntInit;
            r_busy      <= 1'b1;
            r_state     <= StRdWait;
            if (!w_plt) begin
              r_rdata  <= r_rbuf;
              r_rvalid <= 1'b1;
            end
          end
        end
        StRdWait: begin
          if (r_cnt == 2'd0) r_state <= StRdCap;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        StRdCap: begin
          r_rbuf  <= i_vram_rdata;
          r_busy  <= 1'b0;
          r_state <= StIdle;
          if (r_plt) begin
            r_rdata  <= i_vram_rdata;
            r_rvalid <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_reg_rdata  = r_rdata;
  assign o_reg_rvalid = r_rvalid;
  assign o_busy       = r_busy;
  assign o_vram_addr  = r_vram_addr;
  assign o_vram_we    = r_vram_we;
  assign o_vram_wdata = r_vram_wdata;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Scoreboard bench for ppu_vram_port: a behavioural VRAM with RD_LAT latency plus a v/w/rbuf model.
// Palette direct-read cases are exercised when PPU_PLT_DIRECT_RD_EN is defined.
module tb_ppu_vram_port;

  localparam int unsigned RD_LAT = 2;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  wdata = 8'd0;
  logic        inc32 = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  reg_rdata;
  logic        reg_rvalid;
  logic        busy;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  logic [7:0]  mem [0:16383] = '{default: 8'd0};
  logic [13:0] apipe [0:RD_LAT-1] = '{default: 14'd0};

  logic [7:0]  mdl_mem [0:16383] = '{default: 8'd0};
  logic [13:0] mv = 14'd0;
  logic        mw = 1'b0;
  logic [7:0]  mrbuf = 8'd0;

  exp_t wq[$];
  exp_t rq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  ppu_vram_port #(.RD_LAT(RD_LAT)) dut (
    .i_cpu_clk   (clk),
    .i_cpu_rst   (rst),
    .i_reg_cs    (cs),
    .i_reg_sel   (sel),
    .i_reg_we    (we),
    .i_reg_wdata (wdata),
    .i_inc32     (inc32),
    .i_latch_clr (clr),
    .o_reg_rdata (reg_rdata),
    .o_reg_rvalid(reg_rvalid),
    .o_busy      (busy),
    .o_vram_addr (vram_addr),
    .o_vram_we   (vram_we),
    .o_vram_wdata(vram_wdata),
    .i_vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural VRAM: data for the address presented in cycle K is valid in cycle K+RD_LAT.
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr[13:0]] <= vram_wdata;
    apipe[0] <= vram_addr[13:0];
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign vram_rdata = mem[apipe[RD_LAT-1]];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vram_we) begin
      if (wq.size() == 0) chk("unexp_we", 32'd1, 32'd0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", {16'd0, vram_addr}, {16'd0, e.addr});
        chk("wr_data", {24'd0, vram_wdata}, {24'd0, e.data});
        chk("wr_cyc", cyc, e.cyc);
      end
    end
    if (reg_rvalid) begin
      if (rq.size() == 0) chk("unexp_rvalid", 32'd1, 32'd0);
      else begin
        e = rq.pop_front();
        chk("rd_data", {24'd0, reg_rdata}, {24'd0, e.data});
        chk("rd_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic s, input logic w_, input logic [7:0] d, input logic c);
    cs = 1'b1; sel = s; we = w_; wdata = d; clr = c;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; clr = 1'b0;
  endtask

  task automatic step_v();
    mv = mv + (inc32 ? 14'd32 : 14'd1);
  endtask

  task automatic addr_wr(input logic [7:0] d, input logic c);
    if (c) mw = 1'b0;
    else if (!mw) begin mv[13:8] = d[5:0]; mw = 1'b1; end
    else begin mv[7:0] = d; mw = 1'b0; end
    drive(1'b0, 1'b1, d, c);
  endtask

  task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
    addr_wr(hi, 1'b0);
    addr_wr(lo, 1'b0);
  endtask

  task automatic data_wr(input logic [7:0] d);
    wq.push_back('{addr: {2'b00, mv}, data: d, cyc: cyc + 1});
    mdl_mem[mv] = d;
    step_v();
    drive(1'b1, 1'b1, d, 1'b0);
    @(negedge clk);
  endtask

  task automatic data_rd(input bit poke);
    int  n;
    logic plt;
`ifdef PPU_PLT_DIRECT_RD_EN
    plt = (mv[13:8] == 6'h3F);
`else
    plt = 1'b0;
`endif
    if (plt) rq.push_back('{addr: 16'd0, data: mdl_mem[mv], cyc: cyc + 2 + RD_LAT});
    else     rq.push_back('{addr: 16'd0, data: mrbuf, cyc: cyc + 1});
    mrbuf = mdl_mem[mv];
    step_v();
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    n = 0;
    if (poke) begin
      chk("busy_poke", {31'd0, busy}, 32'd1);
      drive(1'b1, 1'b1, 8'h77, 1'b0);
      n = 1;
    end
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, RD_LAT + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, {16'd0, vram_addr}, 32'd0);
    chk({tag, "_we"}, {31'd0, vram_we}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, vram_wdata}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, reg_rdata}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, reg_rvalid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic write and +1 increment.
    set_v(8'h21, 8'h08);
    data_wr(8'h5A);
    data_wr(8'h11);

    // +32 increment and 14-bit wrap.
    set_v(8'h20, 8'h00);
    inc32 = 1'b1;
    data_wr(8'h01);
    data_wr(8'h02);
    data_wr(8'h03);
    inc32 = 1'b0;
    set_v(8'h3F, 8'hFF);
    data_wr(8'h33);
    data_wr(8'h44);
    set_v(8'h3F, 8'hF0);
    inc32 = 1'b1;
    data_wr(8'h55);
    data_wr(8'h66);
    inc32 = 1'b0;

    // Buffered reads: first read returns the reset buffer.
    set_v(8'h24, 8'h00);
    data_wr(8'hAA);
    data_wr(8'hBB);
    set_v(8'h24, 8'h00);
    data_rd(1'b0);
    data_rd(1'b0);
    data_rd(1'b0);

    // Write-toggle clear, alone and coincident with a PPUADDR write.
    addr_wr(8'h23, 1'b0);
    mw = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    set_v(8'h10, 8'h00);
    data_wr(8'h5C);
    addr_wr(8'h15, 1'b0);
    addr_wr(8'h12, 1'b1);
    set_v(8'h05, 8'h06);
    data_wr(8'h6D);

    // A write strobe while busy must be ignored and leave v alone.
    data_rd(1'b1);
    data_wr(8'h7E);

    // Reset during RD_WAIT: no late rvalid and no late buffer load.
    set_v(8'h24, 8'h00);
    data_rd(1'b0);
    rq.push_back('{addr: 16'd0, data: mrbuf, cyc: cyc + 1});
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    mv = 14'd0; mw = 1'b0; mrbuf = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    set_v(8'h24, 8'h00);
    data_rd(1'b0);

`ifdef PPU_PLT_DIRECT_RD_EN
    // Palette read bypasses the buffer and also refills it.
    set_v(8'h3F, 8'h01);
    data_wr(8'h16);
    set_v(8'h3F, 8'h01);
    data_rd(1'b0);
    data_wr(8'h21);
    set_v(8'h24, 8'h00);
    data_rd(1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("wq_empty", wq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
